// File: rtl/snap_pkg.sv
// Shared types and constants for the snapshot capture buffer: FSM state encoding
// and lane-select sizing for the processor read path.
package snap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TRIG,
    ST_FILL,
    ST_POST,
    ST_DONE
  } snap_state_t;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_BUS_W  = 32;

  // A lane select field is always at least one bit wide, even with a single lane.
  function automatic int lane_sel_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  localparam int LANES  = DEF_DATA_W / DEF_BUS_W;
  localparam int LANE_W = lane_sel_w(LANES);

endpackage

// File: rtl/snap_bram_capture_if.sv
// Processor-side read bus of the capture buffer: request address {word, lane},
// registered read data and its valid strobe.
interface snap_bram_capture_if
  import snap_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LANE_W = snap_pkg::LANE_W,
  parameter int BUS_W  = DEF_BUS_W
);

  logic                     bus_en;
  logic [ADDR_W+LANE_W-1:0] bus_addr;
  logic [BUS_W-1:0]         bus_rd_data;
  logic                     bus_rd_valid;

  modport master (
    output bus_en,
    output bus_addr,
    input  bus_rd_data,
    input  bus_rd_valid
  );

  modport slave (
    input  bus_en,
    input  bus_addr,
    output bus_rd_data,
    output bus_rd_valid
  );

endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-first on
// address collision. Written so that synthesis maps it onto block RAM.
module sdp_ram #(
  parameter int W  = 64,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata_q
);

  logic [W-1:0] mem [2**AW];

  // Both accesses share one edge; the non-blocking write makes a colliding read see old data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

endmodule

// File: rtl/snap_bram_capture.sv
// Snapshot capture buffer: arm/trigger FSM writing fabric samples into a dual-port
// RAM (one-shot or circular with post-trigger count), with lane-selected bus readout.
module snap_bram_capture
  import snap_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BUS_W  = DEF_BUS_W,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     din,
  input  logic                  din_valid,
  input  logic                  trig,
  input  logic                  ctrl_arm,
  input  logic                  ctrl_mode,
  input  logic [ADDR_W-1:0]     ctrl_post_cnt,
  output logic                  status_busy,
  output logic                  status_done,
  output logic                  status_wrapped,
  output logic [ADDR_W-1:0]     status_addr,
  snap_bram_capture_if.slave    bus
);

  localparam int NLANES = DATA_W / BUS_W;
  localparam int LSEL_W = lane_sel_w(NLANES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  if (DATA_W % BUS_W != 0) begin : g_width_check
    $error("snap_bram_capture: DATA_W must be an integer multiple of BUS_W");
  end

  snap_state_t       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] post_q, post_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mode_q, mode_d;
  logic              wrapped_q, wrapped_d;
  logic              we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      post_q    <= '0;
      addr_q    <= '0;
      mode_q    <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      post_q    <= post_d;
      addr_q    <= addr_d;
      mode_q    <= mode_d;
      wrapped_q <= wrapped_d;
    end
  end

  // ptr_q always holds the address the next accepted sample will be written to.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    post_d    = post_q;
    addr_d    = addr_q;
    mode_d    = mode_q;
    wrapped_d = wrapped_q;
    we        = 1'b0;

    if (ctrl_arm) begin
      ptr_d     = '0;
      wrapped_d = 1'b0;
      mode_d    = ctrl_mode;
      post_d    = ctrl_post_cnt;
      state_d   = ctrl_mode ? ST_FILL : ST_WAIT_TRIG;
    end else begin
      unique case (state_q)
        ST_WAIT_TRIG: begin
          if (din_valid && trig) begin
            we      = 1'b1;
            ptr_d   = ptr_q + 1'b1;
            state_d = ST_FILL;
          end
        end
        ST_FILL: begin
          if (din_valid) begin
            we    = 1'b1;
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == LAST_ADDR) begin
              if (mode_q) wrapped_d = 1'b1;
              else        state_d   = ST_DONE;
            end
            // Only circular mode reacts to a trigger once filling.
            if (mode_q && trig) begin
              if (post_q == '0) begin
                state_d = ST_DONE;
              end else begin
                cnt_d   = post_q;
                state_d = ST_POST;
              end
            end
          end
        end
        ST_POST: begin
          if (din_valid) begin
            we    = 1'b1;
            ptr_d = ptr_q + 1'b1;
            cnt_d = cnt_q - 1'b1;
            if (ptr_q == LAST_ADDR) wrapped_d = 1'b1;
            if (cnt_q == ADDR_W'(1)) state_d = ST_DONE;
          end
        end
        default: ;
      endcase
    end

    if (we) addr_d = ptr_q;
  end

  assign status_busy    = (state_q == ST_WAIT_TRIG) || (state_q == ST_FILL) || (state_q == ST_POST);
  assign status_done    = (state_q == ST_DONE);
  assign status_wrapped = wrapped_q;
  assign status_addr    = addr_q;

  logic [DATA_W-1:0] ram_q;
  logic [LSEL_W-1:0] lane_q, lane_d;
  logic              rd_valid_q, rd_valid_d;
  logic [BUS_W-1:0]  lane_data;

  sdp_ram #(
    .W  (DATA_W),
    .AW (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we      (we),
    .waddr   (ptr_q),
    .wdata   (din),
    .re      (bus.bus_en),
    .raddr   (bus.bus_addr[ADDR_W+LSEL_W-1 -: ADDR_W]),
    .rdata_q (ram_q)
  );

  // Lane select is registered in step with the RAM output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      lane_q     <= lane_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    rd_valid_d = bus.bus_en;
    lane_d     = bus.bus_en ? bus.bus_addr[LSEL_W-1:0] : lane_q;
  end

  // Lane 0 carries the most significant BUS_W bits of the sample.
  always_comb begin
    lane_data = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (lane_q == LSEL_W'(i)) lane_data = ram_q[DATA_W-1-i*BUS_W -: BUS_W];
    end
  end

  // Gating by valid keeps read data at zero out of reset without resetting the RAM.
  assign bus.bus_rd_data  = rd_valid_q ? lane_data : '0;
  assign bus.bus_rd_valid = rd_valid_q;

endmodule

// File: tb/tb_snap_bram_capture.sv
// Randomized self-checking bench for snap_bram_capture (DATA_W=64, BUS_W=32, ADDR_W=4).
module tb_snap_bram_capture;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] din = '0;
  logic        din_valid = 1'b0;
  logic        trig = 1'b0;
  logic        ctrl_arm = 1'b0;
  logic        ctrl_mode = 1'b0;
  logic [3:0]  ctrl_post_cnt = '0;
  logic        status_busy, status_done, status_wrapped;
  logic [3:0]  status_addr;

  snap_bram_capture_if #(.ADDR_W(4), .LANE_W(1), .BUS_W(32)) bus_if ();

  snap_bram_capture #(.DATA_W(64), .BUS_W(32), .ADDR_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .din            (din),
    .din_valid      (din_valid),
    .trig           (trig),
    .ctrl_arm       (ctrl_arm),
    .ctrl_mode      (ctrl_mode),
    .ctrl_post_cnt  (ctrl_post_cnt),
    .status_busy    (status_busy),
    .status_done    (status_done),
    .status_wrapped (status_wrapped),
    .status_addr    (status_addr),
    .bus            (bus_if.slave)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] mdl [DEPTH];
  bit          known [DEPTH];

  function automatic logic [31:0] lane_of(input logic [63:0] w, input int lane);
    logic [63:0] s;
    s = w >> (32 * (1 - lane));
    return s[31:0];
  endfunction

  task automatic step(input bit v, input logic [63:0] d, input bit t);
    din_valid = v; din = d; trig = t;
    @(negedge clk);
  endtask

  task automatic arm(input bit mode, input logic [3:0] post);
    ctrl_arm = 1'b1; ctrl_mode = mode; ctrl_post_cnt = post;
    din_valid = 1'b0; trig = 1'b0;
    @(negedge clk);
    ctrl_arm = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] data, output logic vld);
    bus_if.bus_en = 1'b1; bus_if.bus_addr = a;
    @(negedge clk);
    data = bus_if.bus_rd_data; vld = bus_if.bus_rd_valid;
    bus_if.bus_en = 1'b0;
  endtask

  task automatic test_readback(input string tag);
    logic [31:0] data, exp;
    logic        vld;
    for (int a = 0; a < 2 * DEPTH; a++) begin
      bus_read(5'(a), data, vld);
      n_checks++;
      if (vld !== 1'b1) begin n_fail++; $display("FAIL %s rd_valid addr %0d: got %b want 1", tag, a, vld); end
      if (known[a/2]) begin
        exp = lane_of(mdl[a/2], a % 2);
        n_checks++;
        if (data !== exp) begin n_fail++; $display("FAIL %s rd_data addr %0d: got %h want %h", tag, a, data, exp); end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks += 6;
    if (status_busy !== 1'b0)    begin n_fail++; $display("FAIL reset busy: got %b want 0", status_busy); end
    if (status_done !== 1'b0)    begin n_fail++; $display("FAIL reset done: got %b want 0", status_done); end
    if (status_wrapped !== 1'b0) begin n_fail++; $display("FAIL reset wrapped: got %b want 0", status_wrapped); end
    if (status_addr !== 4'd0)    begin n_fail++; $display("FAIL reset addr: got %0d want 0", status_addr); end
    if (bus_if.bus_rd_data !== 32'd0) begin n_fail++; $display("FAIL reset rd_data: got %h want 0", bus_if.bus_rd_data); end
    if (bus_if.bus_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset rd_valid: got %b want 0", bus_if.bus_rd_valid); end
    rst = 1'b0;
    @(negedge clk);
    arm(1'b0, 4'd0);
    repeat (50) step(1'($urandom % 2), {$urandom, $urandom}, 1'b0);
    n_checks += 3;
    if (status_busy !== 1'b1) begin n_fail++; $display("FAIL armed_busy: got %b want 1", status_busy); end
    if (status_done !== 1'b0) begin n_fail++; $display("FAIL armed_done: got %b want 0", status_done); end
    if (status_addr !== 4'd0) begin n_fail++; $display("FAIL armed_addr: got %0d want 0", status_addr); end
  endtask

  // One-shot: capture the first DEPTH valid words starting at the first triggered one.
  task automatic test_oneshot(input bit rand_data, input bit fixed_checks);
    logic [63:0] cap [$];
    logic [63:0] d;
    logic [31:0] data;
    logic        vld;
    bit          v, t, started;
    int          k;
    started = 1'b0; k = 0;
    arm(1'b0, 4'($urandom));
    for (int i = 0; i < 3; i++) step(1'b1, 64'hDEAD_0000 + 64'(i), 1'b0);
    for (int cyc = 0; cyc < 200 && k < 24; cyc++) begin
      v = ($urandom % 3) != 0;
      if (v) begin
        d = rand_data ? {$urandom, $urandom} : 64'h100 + 64'(k);
        t = (k == 0) || ($urandom % 4 == 0);
        k++;
      end else begin
        d = {$urandom, $urandom}; t = 1'($urandom % 2);
      end
      if (v && (started || t) && cap.size() < DEPTH) begin started = 1'b1; cap.push_back(d); end
      step(v, d, t);
      n_checks++;
      if (status_done !== (cap.size() == DEPTH)) begin
        n_fail++; $display("FAIL oneshot done word %0d: got %b want %b", cap.size(), status_done, cap.size() == DEPTH);
      end
    end
    n_checks += 4;
    if (status_busy !== 1'b0)    begin n_fail++; $display("FAIL oneshot busy: got %b want 0", status_busy); end
    if (status_done !== 1'b1)    begin n_fail++; $display("FAIL oneshot done_end: got %b want 1", status_done); end
    if (status_addr !== 4'd15)   begin n_fail++; $display("FAIL oneshot addr: got %0d want 15", status_addr); end
    if (status_wrapped !== 1'b0) begin n_fail++; $display("FAIL oneshot wrapped: got %b want 0", status_wrapped); end
    for (int i = 0; i < cap.size(); i++) begin mdl[i] = cap[i]; known[i] = 1'b1; end
    if (fixed_checks) begin
      bus_read(5'd0, data, vld);
      n_checks++; if (data !== 32'h0) begin n_fail++; $display("FAIL oneshot bus0: got %h want 00000000", data); end
      bus_read(5'd1, data, vld);
      n_checks++; if (data !== 32'h100) begin n_fail++; $display("FAIL oneshot bus1: got %h want 00000100", data); end
      bus_read(5'd31, data, vld);
      n_checks++; if (data !== 32'h10F) begin n_fail++; $display("FAIL oneshot bus31: got %h want 0000010f", data); end
    end
    test_readback("oneshot");
  endtask

  // Circular: keep every valid word until the trigger word plus post more words.
  task automatic test_circular(input int n_words, input int trig_idx, input logic [3:0] post,
                               input bit rand_data, input bit fixed_checks);
    logic [63:0] seq [$];
    logic [63:0] d;
    logic [31:0] data;
    logic [3:0]  exp_addr;
    logic        vld;
    bit          v, t, seen, fin;
    int          k, remaining;
    seen = 1'b0; fin = 1'b0; k = 0; remaining = 0;
    arm(1'b1, post);
    for (int cyc = 0; cyc < 500 && k < n_words; cyc++) begin
      v = ($urandom % 4) != 0;
      if (v) begin
        d = rand_data ? {$urandom, $urandom} : 64'(k);
        t = (k == trig_idx);
        k++;
      end else begin
        d = {$urandom, $urandom}; t = 1'($urandom % 2);
      end
      if (v && !fin) begin
        seq.push_back(d);
        if (seen) remaining--;
        else if (t) begin seen = 1'b1; remaining = int'(post); end
        fin = seen && (remaining == 0);
      end
      step(v, d, t);
      n_checks++;
      if (status_done !== fin) begin n_fail++; $display("FAIL circ done at word %0d: got %b want %b", seq.size(), status_done, fin); end
    end
    exp_addr = 4'((seq.size() - 1) % DEPTH);
    n_checks += 3;
    if (status_busy !== !fin) begin n_fail++; $display("FAIL circ busy: got %b want %b", status_busy, !fin); end
    if (status_wrapped !== (seq.size() > DEPTH)) begin
      n_fail++; $display("FAIL circ wrapped: got %b want %b", status_wrapped, seq.size() > DEPTH);
    end
    if (status_addr !== exp_addr) begin n_fail++; $display("FAIL circ addr: got %0d want %0d", status_addr, exp_addr); end
    for (int i = 0; i < seq.size(); i++) begin mdl[i % DEPTH] = seq[i]; known[i % DEPTH] = 1'b1; end
    if (fixed_checks) begin
      n_checks += 2;
      if (status_addr !== 4'd7)    begin n_fail++; $display("FAIL circ3 addr: got %0d want 7", status_addr); end
      if (status_wrapped !== 1'b1) begin n_fail++; $display("FAIL circ3 wrapped: got %b want 1", status_wrapped); end
      bus_read(5'd15, data, vld);
      n_checks++; if (data !== 32'd23) begin n_fail++; $display("FAIL circ3 mem7: got %h want 00000017", data); end
      bus_read(5'd17, data, vld);
      n_checks++; if (data !== 32'd8) begin n_fail++; $display("FAIL circ3 mem8: got %h want 00000008", data); end
    end
    test_readback("circ");
  endtask

  task automatic test_post0_rearm();
    logic [63:0] d;
    arm(1'b1, 4'd0);
    for (int i = 0; i < 6; i++) begin
      d = {$urandom, $urandom};
      step(1'b1, d, i == 5);
      mdl[i] = d; known[i] = 1'b1;
      n_checks++;
      if (status_done !== (i == 5)) begin n_fail++; $display("FAIL post0 done word %0d: got %b want %b", i, status_done, i == 5); end
    end
    n_checks += 2;
    if (status_addr !== 4'd5)    begin n_fail++; $display("FAIL post0 addr: got %0d want 5", status_addr); end
    if (status_wrapped !== 1'b0) begin n_fail++; $display("FAIL post0 wrapped: got %b want 0", status_wrapped); end
    arm(1'b1, 4'd2);
    for (int i = 0; i < 20; i++) begin
      d = {$urandom, $urandom};
      step(1'b1, d, 1'b0);
      mdl[i % DEPTH] = d;
    end
    n_checks += 2;
    if (status_wrapped !== 1'b1) begin n_fail++; $display("FAIL rearm pre wrapped: got %b want 1", status_wrapped); end
    if (status_busy !== 1'b1)    begin n_fail++; $display("FAIL rearm pre busy: got %b want 1", status_busy); end
    arm(1'b1, 4'd1);
    n_checks += 3;
    if (status_busy !== 1'b1)    begin n_fail++; $display("FAIL rearm busy: got %b want 1", status_busy); end
    if (status_done !== 1'b0)    begin n_fail++; $display("FAIL rearm done: got %b want 0", status_done); end
    if (status_wrapped !== 1'b0) begin n_fail++; $display("FAIL rearm wrapped: got %b want 0", status_wrapped); end
    for (int i = 0; i < 4; i++) begin
      d = {$urandom, $urandom};
      step(1'b1, d, i == 2);
      mdl[i] = d;
      n_checks++;
      if (status_done !== (i == 3)) begin n_fail++; $display("FAIL rearm done word %0d: got %b want %b", i, status_done, i == 3); end
    end
    n_checks++;
    if (status_addr !== 4'd3) begin n_fail++; $display("FAIL rearm addr: got %0d want 3", status_addr); end
    test_readback("rearm");
  endtask

  task automatic test_rst_mid_post();
    logic [63:0] d;
    arm(1'b1, 4'd10);
    for (int i = 0; i < 5; i++) begin
      d = {$urandom, $urandom};
      step(1'b1, d, i == 2);
      mdl[i] = d; known[i] = 1'b1;
    end
    #2 rst = 1'b1;
    #1;
    n_checks += 3;
    if (status_busy !== 1'b0) begin n_fail++; $display("FAIL rstpost busy: got %b want 0", status_busy); end
    if (status_done !== 1'b0) begin n_fail++; $display("FAIL rstpost done: got %b want 0", status_done); end
    if (status_addr !== 4'd0) begin n_fail++; $display("FAIL rstpost addr: got %0d want 0", status_addr); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_oneshot(1'b1, 1'b0);
  endtask

  task automatic test_read_during_write();
    logic [63:0] old_w, new_w;
    logic [31:0] data;
    logic        vld;
    old_w = mdl[0];
    new_w = {$urandom, $urandom};
    arm(1'b0, 4'd0);
    din = new_w; din_valid = 1'b1; trig = 1'b1;
    bus_if.bus_en = 1'b1; bus_if.bus_addr = 5'd1;
    @(negedge clk);
    din_valid = 1'b0; trig = 1'b0; bus_if.bus_en = 1'b0;
    n_checks += 3;
    if (bus_if.bus_rd_valid !== 1'b1) begin n_fail++; $display("FAIL rdw valid: got %b want 1", bus_if.bus_rd_valid); end
    if (bus_if.bus_rd_data !== lane_of(old_w, 1)) begin
      n_fail++; $display("FAIL rdw old data: got %h want %h", bus_if.bus_rd_data, lane_of(old_w, 1));
    end
    if (status_addr !== 4'd0) begin n_fail++; $display("FAIL rdw addr: got %0d want 0", status_addr); end
    @(negedge clk);
    n_checks++;
    if (bus_if.bus_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rdw valid width: got %b want 0", bus_if.bus_rd_valid); end
    mdl[0] = new_w;
    bus_read(5'd0, data, vld);
    n_checks++; if (data !== lane_of(new_w, 0)) begin n_fail++; $display("FAIL rdw new lane0: got %h want %h", data, lane_of(new_w, 0)); end
    bus_read(5'd1, data, vld);
    n_checks++; if (data !== lane_of(new_w, 1)) begin n_fail++; $display("FAIL rdw new lane1: got %h want %h", data, lane_of(new_w, 1)); end
  endtask

  initial begin
    int trig_idx, post;
    bus_if.bus_en = 1'b0;
    bus_if.bus_addr = '0;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    #2;
    test_reset();
    test_oneshot(1'b0, 1'b1);
    test_circular(40, 20, 4'd3, 1'b0, 1'b1);
    for (int r = 0; r < 3; r++) begin
      trig_idx = $urandom_range(0, 30);
      post     = $urandom_range(0, 15);
      test_circular(trig_idx + post + 1 + $urandom_range(0, 5), trig_idx, 4'(post), 1'b1, 1'b0);
    end
    test_post0_rearm();
    test_rst_mid_post();
    test_read_during_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
